// File: rtl/branch_resolve_if.sv
// branch_resolve_if: EX-side branch inputs and MEM-side update/redirect outputs (stat ports under BRU_STATS_EN)
interface branch_resolve_if #(parameter int XLEN = 32);
  logic            ex_valid;
  logic            ex_stall;
  logic            ex_is_branch;
  logic [2:0]      ex_funct3;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_rs1;
  logic [XLEN-1:0] ex_rs2;
  logic [XLEN-1:0] ex_imm;
  logic            ex_pred_taken;
  logic            ex_pred_hit;
  logic [XLEN-1:0] ex_pred_target;
  logic            upd_valid;
  logic [XLEN-1:0] mem_pc;
  logic            mem_is_taken;
  logic [XLEN-1:0] t_addr;
  logic            miss_predict;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            squash;
`ifdef BRU_STATS_EN
  logic [XLEN-1:0] stat_branches;
  logic [XLEN-1:0] stat_mispredicts;
`endif
  modport master (
    output ex_valid, ex_stall, ex_is_branch, ex_funct3, ex_pc, ex_rs1, ex_rs2, ex_imm,
           ex_pred_taken, ex_pred_hit, ex_pred_target,
`ifdef BRU_STATS_EN
    input  stat_branches, stat_mispredicts,
`endif
    input  upd_valid, mem_pc, mem_is_taken, t_addr, miss_predict, redirect, redirect_pc, squash
  );
  modport slave (
    input  ex_valid, ex_stall, ex_is_branch, ex_funct3, ex_pc, ex_rs1, ex_rs2, ex_imm,
           ex_pred_taken, ex_pred_hit, ex_pred_target,
`ifdef BRU_STATS_EN
    output stat_branches, stat_mispredicts,
`endif
    output upd_valid, mem_pc, mem_is_taken, t_addr, miss_predict, redirect, redirect_pc, squash
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves EX branches, registers MEM update/redirect, squashes wrong path on mispredict.
// Optional BRU_STATS_EN adds saturating branch/mispredict counters.
module branch_resolve_unit #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input logic             clk,
  input logic             rst,
  branch_resolve_if.slave bus
);
  typedef enum logic {IDLE, FLUSH} state_t;
  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            upd_q, upd_d, miss_q, miss_d, taken_q, taken_d;
  logic [XLEN-1:0] mem_pc_q, mem_pc_d, t_addr_q, t_addr_d, rpc_q, rpc_d;
  logic            eq, lt, ltu, legal, taken, accept, mispredict;
  logic [XLEN-1:0] target, fall, actual_next, pred_next;
  always_comb begin
    eq          = bus.ex_rs1 == bus.ex_rs2;
    lt          = $signed(bus.ex_rs1) < $signed(bus.ex_rs2);
    ltu         = bus.ex_rs1 < bus.ex_rs2;
    legal       = bus.ex_funct3[2] | ~bus.ex_funct3[1];
    // funct3[0] inverts the base comparison (BNE/BGE/BGEU)
    taken       = (bus.ex_funct3[2] ? (bus.ex_funct3[1] ? ltu : lt) : eq) ^ bus.ex_funct3[0];
    target      = bus.ex_pc + bus.ex_imm;
    fall        = bus.ex_pc + XLEN'(4);
    actual_next = taken ? target : fall;
    pred_next   = (bus.ex_pred_taken & bus.ex_pred_hit) ? bus.ex_pred_target : fall;
    mispredict  = actual_next != pred_next;
    accept      = bus.ex_valid & bus.ex_is_branch & ~bus.ex_stall & (state_q == IDLE) & legal;
    state_d     = state_q;
    cnt_d       = cnt_q;
    if (state_q == FLUSH) begin
      state_d = (cnt_q == 4'd0) ? IDLE : FLUSH;
      cnt_d   = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
    end else if (accept & mispredict) begin
      state_d = FLUSH;
      cnt_d   = 4'(FLUSH_CYCLES - 1);
    end
    upd_d    = accept;
    miss_d   = accept & mispredict;
    mem_pc_d = accept ? bus.ex_pc : mem_pc_q;
    taken_d  = accept ? taken : taken_q;
    t_addr_d = accept ? target : t_addr_q;
    rpc_d    = accept ? actual_next : rpc_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      upd_q    <= 1'b0;
      miss_q   <= 1'b0;
      taken_q  <= 1'b0;
      mem_pc_q <= '0;
      t_addr_q <= '0;
      rpc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      upd_q    <= upd_d;
      miss_q   <= miss_d;
      taken_q  <= taken_d;
      mem_pc_q <= mem_pc_d;
      t_addr_q <= t_addr_d;
      rpc_q    <= rpc_d;
    end
  end
  assign bus.upd_valid    = upd_q;
  assign bus.mem_pc       = mem_pc_q;
  assign bus.mem_is_taken = taken_q;
  assign bus.t_addr       = t_addr_q;
  assign bus.miss_predict = miss_q;
  assign bus.redirect     = miss_q;
  assign bus.redirect_pc  = rpc_q;
  assign bus.squash       = state_q == FLUSH;
`ifdef BRU_STATS_EN
  logic [XLEN-1:0] stat_br_q, stat_br_d, stat_mp_q, stat_mp_d;
  always_comb begin
    stat_br_d = stat_br_q + XLEN'(accept & ~&stat_br_q);
    stat_mp_d = stat_mp_q + XLEN'(accept & mispredict & ~&stat_mp_q);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end
  assign bus.stat_branches    = stat_br_q;
  assign bus.stat_mispredicts = stat_mp_q;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed + random stimulus, reference model feeds a scoreboard queue checked by a monitor.
module tb_branch_resolve_unit;
  localparam int FL = 2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  branch_resolve_if #(.XLEN(32)) ifc ();
  branch_resolve_unit #(.XLEN(32), .FLUSH_CYCLES(FL)) dut (.clk(clk), .rst(rst), .bus(ifc));
  typedef struct packed {
    logic [31:0] pc;
    logic        tk;
    logic [31:0] tgt;
    logic        ms;
    logic [31:0] rpc;
  } exp_t;
  exp_t q[$];
  exp_t last;
  int   checks = 0;
  int   failures = 0;
  int   sq_rem = 0;
  bit   mon_en = 1'b0;
  longint n_acc = 0;
  longint n_mis = 0;
  task automatic chk(string name, logic [127:0] act, logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask
  function automatic bit ref_taken(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    case (f)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return ua < ub;
      3'd7: return ua >= ub;
      default: return 1'b0;
    endcase
  endfunction
  task automatic step();
    exp_t e;
    bit   acc, tk;
    logic [31:0] fall, pn;
    tk    = ref_taken(ifc.ex_funct3, ifc.ex_rs1, ifc.ex_rs2);
    fall  = ifc.ex_pc + 32'd4;
    e.pc  = ifc.ex_pc;
    e.tk  = tk;
    e.tgt = ifc.ex_pc + ifc.ex_imm;
    e.rpc = tk ? e.tgt : fall;
    pn    = (ifc.ex_pred_taken && ifc.ex_pred_hit) ? ifc.ex_pred_target : fall;
    e.ms  = e.rpc != pn;
    acc   = rst && ifc.ex_valid && ifc.ex_is_branch && !ifc.ex_stall && sq_rem == 0 &&
            ifc.ex_funct3 inside {3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    @(posedge clk);
    if (!rst) begin
      sq_rem = 0;
      q.delete();
      last  = '0;
      n_acc = 0;
      n_mis = 0;
    end else begin
      if (acc) begin
        q.push_back(e);
        n_acc++;
        if (e.ms) n_mis++;
      end
      if (acc && e.ms) sq_rem = FL;
      else if (sq_rem > 0) sq_rem--;
    end
    #1;
  endtask
  task automatic br(logic [2:0] f, logic [31:0] pc, logic [31:0] a, logic [31:0] b, logic [31:0] imm,
                    bit pt, bit hit, logic [31:0] ptgt);
    ifc.ex_valid = 1'b1; ifc.ex_is_branch = 1'b1; ifc.ex_stall = 1'b0;
    ifc.ex_funct3 = f; ifc.ex_pc = pc; ifc.ex_rs1 = a; ifc.ex_rs2 = b; ifc.ex_imm = imm;
    ifc.ex_pred_taken = pt; ifc.ex_pred_hit = hit; ifc.ex_pred_target = ptgt;
  endtask
  task automatic idle(int n);
    ifc.ex_valid = 1'b0;
    repeat (n) step();
  endtask
  task automatic rand_inputs();
    ifc.ex_valid = $urandom_range(0, 3) != 0;
    ifc.ex_is_branch = $urandom_range(0, 7) != 0;
    ifc.ex_stall = $urandom_range(0, 5) == 0;
    ifc.ex_funct3 = 3'($urandom);
    ifc.ex_pc = $urandom & 32'hFFFF_FFFC;
    ifc.ex_rs1 = $urandom;
    ifc.ex_rs2 = ($urandom_range(0, 3) == 0) ? ifc.ex_rs1 : $urandom;
    ifc.ex_imm = {{20{ifc.ex_rs1[11]}}, $urandom_range(0, 4095) & 12'hFFE};
    ifc.ex_pred_taken = 1'($urandom);
    ifc.ex_pred_hit = 1'($urandom);
    ifc.ex_pred_target = $urandom_range(0, 1) ? ifc.ex_pc + ifc.ex_imm : $urandom;
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      chk("squash", 128'(ifc.squash), 128'(sq_rem > 0));
      chk("upd_valid", 128'(ifc.upd_valid), 128'(q.size() != 0));
      if (q.size() != 0) begin
        e = q.pop_front();
        if (ifc.upd_valid) begin
          chk("mem_pc", 128'(ifc.mem_pc), 128'(e.pc));
          chk("mem_is_taken", 128'(ifc.mem_is_taken), 128'(e.tk));
          chk("t_addr", 128'(ifc.t_addr), 128'(e.tgt));
          chk("miss_predict", 128'(ifc.miss_predict), 128'(e.ms));
          chk("redirect", 128'(ifc.redirect), 128'(e.ms));
          chk("redirect_pc", 128'(ifc.redirect_pc), 128'(e.rpc));
          last = e;
        end
      end else if (!ifc.upd_valid) begin
        chk("pulses_low", 128'({ifc.miss_predict, ifc.redirect}), 128'(0));
        chk("hold", 128'({ifc.mem_pc, ifc.mem_is_taken, ifc.t_addr, ifc.redirect_pc}),
            128'({last.pc, last.tk, last.tgt, last.rpc}));
      end
    end
  end
  initial begin
    last = '0;
    rst = 1'b0;
    repeat (3) begin
      rand_inputs();
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("reset_outputs", 128'({ifc.upd_valid, ifc.miss_predict, ifc.redirect, ifc.squash, ifc.mem_is_taken}), 128'(0));
    chk("reset_data", 128'({ifc.mem_pc, ifc.t_addr, ifc.redirect_pc}), 128'(0));
    rst = 1'b1;
    mon_en = 1'b1;
    idle(1);
    br(3'b000, 32'h100, 32'd5, 32'd6, 32'h20, 1'b0, 1'b0, 32'h0); step();
    idle(1);
    br(3'b100, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b0, 1'b0, 32'h0); step();
    br(3'b000, 32'h500, 32'd7, 32'd7, 32'h8, 1'b0, 1'b0, 32'h0); step(); step();
    idle(1);
    br(3'b110, 32'h2F0, 32'd1, 32'hFFFF_FFFF, 32'h14, 1'b1, 1'b1, 32'h300); step();
    idle(FL + 1);
    br(3'b101, 32'hFFFF_FFFC, 32'd1, 32'd2, 32'h40, 1'b1, 1'b1, 32'h1000); step();
    idle(FL + 1);
    br(3'b000, 32'h10, 32'd3, 32'd3, 32'hFFFF_FFE0, 1'b1, 1'b1, 32'hFFFF_FFF0); step();
    br(3'b001, 32'h14, 32'd3, 32'd4, 32'h8, 1'b1, 1'b1, 32'h1C); step();
    br(3'b010, 32'h18, 32'd3, 32'd4, 32'h8, 1'b0, 1'b0, 32'h0); step();
    br(3'b111, 32'h40, 32'd9, 32'd9, 32'h10, 1'b0, 1'b0, 32'h0); ifc.ex_stall = 1'b1;
    repeat (3) step();
    ifc.ex_stall = 1'b0; step();
    idle(FL + 1);
    br(3'b001, 32'h80, 32'd1, 32'd2, 32'h100, 1'b0, 1'b0, 32'h0); step();
    idle(1);
    rst = 1'b0; step();
    rst = 1'b1; idle(2);
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      rst = $urandom_range(0, 99) != 0;
      step();
    end
    rst = 1'b1;
    idle(FL + 2);
`ifdef BRU_STATS_EN
    chk("stat_branches", 128'(ifc.stat_branches), 128'(n_acc));
    chk("stat_mispredicts", 128'(ifc.stat_mispredicts), 128'(n_mis));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
